exs_complete_arbiter: RTL

// - Parametrised completion buffer/arbiter between the execution-stage FUs and the complete stage.
// - Each FU pushes finished packets into its own DEPTH-entry FIFO.
// - Up to NUM_CDB FIFO heads per cycle are granted onto the CDB lanes in round-robin order.
// - Per-FU stall replaces the fixed single-slot hazard handshake; flush squashes all buffered work on mispredict.

---
 rtl/exs_complete_arbiter_pkg.sv | 20 ++
 rtl/exs_fu_fifo.sv | 68 ++++++
 rtl/exs_complete_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/exs_complete_arbiter_pkg.sv
// Shared sizing, derived widths and the CDB lane record for the completion arbiter.
// The arbiter is resized by editing the constants here.
package exs_complete_arbiter_pkg;

  localparam int unsigned NUM_FU   = 9;
  localparam int unsigned NUM_CDB  = 3;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned PKT_W    = 96;

  localparam int unsigned FU_IDX_W = $clog2(NUM_FU);
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W    = $clog2(NUM_FU * DEPTH + 1);

  typedef struct packed {
    logic                valid;
    logic [FU_IDX_W-1:0] src;
    logic [PKT_W-1:0]    pkt;
  } cdb_lane_packet_t;

endpackage

// File: rtl/exs_fu_fifo.sv
// Per-FU completion FIFO: circular buffer with async-reset pointers and a synchronous flush.
module exs_fu_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 96,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             full
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & (count_q != '0) & ~flush;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CntW'(1);
      else if (do_pop && !do_push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/exs_complete_arbiter.sv
// Completion buffer/arbiter: per-FU FIFOs drained onto NUM_CDB CDB lanes by a rotating
// round-robin multi-grant scan; flush squashes all buffered and incoming work.
module exs_complete_arbiter
  import exs_complete_arbiter_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*PKT_W-1:0]     fu_pkt,
  output logic [NUM_FU-1:0]           fu_stall,
  input  logic                        flush,
  output logic [NUM_CDB-1:0]          cdb_valid,
  output logic [NUM_CDB*PKT_W-1:0]    cdb_pkt,
  output logic [NUM_CDB*FU_IDX_W-1:0] cdb_src,
  output logic [OCC_W-1:0]            occupancy
);

  localparam int unsigned LaneW = $clog2(NUM_CDB + 1);

  logic [NUM_FU-1:0]     push, pop, req;
  logic [2*NUM_FU-1:0]   req2;
  logic [CNT_W-1:0]      count [NUM_FU];
  logic [PKT_W-1:0]      head  [NUM_FU];
  logic [FU_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [FU_IDX_W:0]     pos;
  logic [FU_IDX_W-1:0]   idx;
  logic [LaneW-1:0]      n_grant;
  cdb_lane_packet_t      lane [NUM_CDB];

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    assign push[i] = fu_valid[i] & ~fu_stall[i] & ~flush;
    assign req[i]  = (count[i] != '0);

    exs_fu_fifo #(
      .Depth (DEPTH),
      .Width (PKT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .flush (flush),
      .din   (fu_pkt[i*PKT_W +: PKT_W]),
      .dout  (head[i]),
      .count (count[i]),
      .full  (fu_stall[i])
    );
  end

  // Doubling the request vector turns the wrapped scan from rr_ptr into a linear one.
  assign req2 = {req, req};

  always_comb begin
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    n_grant  = '0;
    pos      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_CDB; k++) lane[k] = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      pos = {1'b0, rr_ptr_q} + (FU_IDX_W+1)'(j);
      idx = (pos >= (FU_IDX_W+1)'(NUM_FU)) ? FU_IDX_W'(pos - (FU_IDX_W+1)'(NUM_FU))
                                           : FU_IDX_W'(pos);
      if (!flush && req2[pos] && (n_grant < LaneW'(NUM_CDB))) begin
        lane[n_grant].valid = 1'b1;
        lane[n_grant].src   = idx;
        lane[n_grant].pkt   = head[idx];
        pop[idx]            = 1'b1;
        rr_ptr_d            = (idx == FU_IDX_W'(NUM_FU - 1)) ? '0 : idx + FU_IDX_W'(1);
        n_grant             = n_grant + LaneW'(1);
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) occ_d = occ_d + OCC_W'(1);
      if (pop[i])  occ_d = occ_d - OCC_W'(1);
    end
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rr_ptr_q <= flush ? '0 : rr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
    assign cdb_valid[k]                       = lane[k].valid;
    assign cdb_pkt[k*PKT_W +: PKT_W]          = lane[k].pkt;
    assign cdb_src[k*FU_IDX_W +: FU_IDX_W]    = lane[k].src;
  end

  assign occupancy = occ_q;

endmodule
